// File: rtl/snake_seg_reader.sv
// Purpose : snapshots a packed snake coordinate frame on start and streams it
//           out one segment per beat, head (slot 0) first.
// Latency : first beat is valid on the cycle after start; one beat per cycle
//           while segReady is held; a one-cycle done pulse follows the last beat.
// Backpr. : valid/ready. segValid comes only from registered state; the current
//           beat is held stable while segReady is low.
// Ports   : clock/reset (async, active-low), start/abort control,
//           snakeLocX/snakeLocY/size frame input, segReady from the consumer,
//           segValid/segX/segY/segIndex/segLast beat output, busy/done status.
module snake_seg_reader #(
   parameter int MaxSegments = 128,
   parameter int XWidth      = 8,
   parameter int YWidth      = 9
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          abort,
   input  logic [MaxSegments*XWidth-1:0] snakeLocX,
   input  logic [MaxSegments*YWidth-1:0] snakeLocY,
   input  logic [7:0]                    size,
   input  logic                          segReady,
   output logic                          segValid,
   output logic [XWidth-1:0]             segX,
   output logic [YWidth-1:0]             segY,
   output logic [6:0]                    segIndex,
   output logic                          segLast,
   output logic                          busy,
   output logic                          done
);

   localparam logic [7:0] MaxCount = 8'(MaxSegments);

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DONE
   } state_t;

   state_t                        state_q;
   state_t                        state_d;
   logic [MaxSegments*XWidth-1:0] snap_x;
   logic [MaxSegments*YWidth-1:0] snap_y;
   logic [7:0]                    count_q;
   logic [6:0]                    idx_q;
   logic [6:0]                    idx_d;
   logic                          load;
   logic [7:0]                    size_clamped;
   logic                          at_last;

   // Requests larger than the slot count stream every slot and no more.
   assign size_clamped = (size > MaxCount) ? MaxCount : size;

   // count_q is never zero while in STREAM, so count_q - 1 cannot underflow there.
   assign at_last = ({1'b0, idx_q} == (count_q - 8'd1));

   // Outputs decode registered state only; segReady never reaches segValid.
   assign segValid = (state_q == STREAM);
   assign segLast  = segValid & at_last;
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign segIndex = idx_q;
   assign segX     = segValid ? snap_x[int'(idx_q)*XWidth +: XWidth] : '0;
   assign segY     = segValid ? snap_y[int'(idx_q)*YWidth +: YWidth] : '0;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      load    = 1'b0;
      case (state_q)
         IDLE: begin
            // abort outranks start even though abort is otherwise a no-op here.
            if (!abort && start) begin
               load    = 1'b1;
               idx_d   = 7'd0;
               state_d = (size_clamped == 8'd0) ? DONE : STREAM;
            end
         end
         STREAM: begin
            // abort wins over a handshake on the same edge: the index is left
            // alone and no done pulse is produced.
            if (abort) begin
               state_d = IDLE;
            end else if (segReady) begin
               if (at_last) begin
                  state_d = DONE;
               end else begin
                  idx_d = idx_q + 7'd1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         count_q <= '0;
         snap_x  <= '0;
         snap_y  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         if (load) begin
            snap_x  <= snakeLocX;
            snap_y  <= snakeLocY;
            count_q <= size_clamped;
         end
      end
   end

endmodule

// File: tb/tb_snake_seg_reader.sv
module tb_snake_seg_reader;

   localparam int MS = 128;
   localparam int XW = 8;
   localparam int YW = 9;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic             segReady = 1'b0;
   logic [MS*XW-1:0] snakeLocX = '0;
   logic [MS*YW-1:0] snakeLocY = '0;
   logic [7:0]       size = 8'd0;
   logic             segValid;
   logic [XW-1:0]    segX;
   logic [YW-1:0]    segY;
   logic [6:0]       segIndex;
   logic             segLast;
   logic             busy;
   logic             done;

   snake_seg_reader #(.MaxSegments(MS), .XWidth(XW), .YWidth(YW)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .abort     (abort),
      .snakeLocX (snakeLocX),
      .snakeLocY (snakeLocY),
      .size      (size),
      .segReady  (segReady),
      .segValid  (segValid),
      .segX      (segX),
      .segY      (segY),
      .segIndex  (segIndex),
      .segLast   (segLast),
      .busy      (busy),
      .done      (done)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      logic [6:0]    idx;
      logic          last;
   } beat_t;

   typedef struct {
      string       name;
      logic [31:0] act;
      logic [31:0] exp;
   } chk_t;

   beat_t exp_q[$];
   chk_t  chk_q[$];
   beat_t mon_e;
   chk_t  mon_c;
   int    n_cmp = 0;
   int    n_fail = 0;
   int    hs_cnt = 0;
   int    done_cnt = 0;
   int    d0;
   int    h0;
   int    cyc;

   // Monitor: drains directed checks and scores every presented beat against
   // the head of the expected queue; a beat is retired on handshake.
   always @(negedge clock) begin
      while (chk_q.size() > 0) begin
         mon_c = chk_q.pop_front();
         n_cmp++;
         if (mon_c.act !== mon_c.exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", mon_c.name, mon_c.act, mon_c.exp);
         end
      end
      if (reset) begin
         if (done) done_cnt++;
         if (segValid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL beat_unexpected: got idx=%0d x=%0d y=%0d, expected no beat",
                        segIndex, segX, segY);
            end else begin
               mon_e = exp_q[0];
               if ({segX, segY, segIndex, segLast} !== mon_e) begin
                  n_fail++;
                  $display("FAIL beat: got x=%0d y=%0d idx=%0d last=%0d, expected x=%0d y=%0d idx=%0d last=%0d",
                           segX, segY, segIndex, segLast, mon_e.x, mon_e.y, mon_e.idx, mon_e.last);
               end
               if (segReady) begin
                  void'(exp_q.pop_front());
                  hs_cnt++;
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_t c;
      c.name = name;
      c.act  = act;
      c.exp  = exp;
      chk_q.push_back(c);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_slot(input int i, input int x, input int y);
      snakeLocX[i*XW +: XW] = XW'(x);
      snakeLocY[i*YW +: YW] = YW'(y);
   endtask

   task automatic push_beat(input int x, input int y, input int i, input bit last);
      beat_t b;
      b.x    = XW'(x);
      b.y    = YW'(y);
      b.idx  = 7'(i);
      b.last = last;
      exp_q.push_back(b);
   endtask

   task automatic frame3();
      set_slot(0, 50, 60);
      set_slot(1, 40, 60);
      set_slot(2, 30, 60);
      size = 8'd3;
   endtask

   task automatic push_frame3();
      push_beat(50, 60, 0, 1'b0);
      push_beat(40, 60, 1, 1'b0);
      push_beat(30, 60, 2, 1'b1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, 32'(segValid), 0);
      check({tag, "_x"},     32'(segX), 0);
      check({tag, "_y"},     32'(segY), 0);
      check({tag, "_idx"},   32'(segIndex), 0);
      check({tag, "_last"},  32'(segLast), 0);
      check({tag, "_busy"},  32'(busy), 0);
      check({tag, "_done"},  32'(done), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state, including a start that must be ignored while in reset.
      frame3();
      start = 1'b1;
      #12;
      check_all_zero("rst");
      tick();
      check("rst_start_ignored", 32'(busy), 0);
      start = 1'b0;

      // Basic frame, start on the first edge after reset release.
      reset = 1'b1;
      segReady = 1'b1;
      start = 1'b1;
      push_frame3();
      d0 = done_cnt;
      tick();                       // cycle +1
      start = 1'b0;
      check("t1_valid_c1", 32'(segValid), 1);
      check("t1_idx_c1", 32'(segIndex), 0);
      tick();                       // +2
      tick();                       // +3
      check("t1_last_c3", 32'(segLast), 1);
      tick();                       // +4
      check("t1_done_c4", 32'(done), 1);
      check("t1_valid_c4", 32'(segValid), 0);
      check("t1_busy_c4", 32'(busy), 1);
      tick();                       // +5
      check("t1_busy_c5", 32'(busy), 0);
      check("t1_done_c5", 32'(done), 0);
      check("t1_done_count", 32'(done_cnt - d0), 1);

      // Backpressure: ready 1,0,0,1,1.
      push_frame3();
      d0 = done_cnt;
      h0 = hs_cnt;
      start = 1'b1;
      tick();                       // +1 ready=1
      start = 1'b0;
      tick();                       // +2
      segReady = 1'b0;
      check("t2_stall1_idx", 32'(segIndex), 1);
      tick();                       // +3
      check("t2_stall2_idx", 32'(segIndex), 1);
      check("t2_stall2_x", 32'(segX), 40);
      tick();                       // +4
      segReady = 1'b1;
      tick();                       // +5
      tick();                       // +6
      check("t2_done", 32'(done), 1);
      tick();
      check("t2_handshakes", 32'(hs_cnt - h0), 3);
      check("t2_done_count", 32'(done_cnt - d0), 1);

      // size = 0: straight to DONE, no beats.
      size = 8'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t3_valid", 32'(segValid), 0);
      check("t3_done", 32'(done), 1);
      tick();
      check("t3_busy_after", 32'(busy), 0);

      // size = 200 clamps to 128 beats.
      for (int i = 0; i < MS; i++) begin
         set_slot(i, i, i + 256);
         push_beat(i, i + 256, i, i == MS - 1);
      end
      size = 8'd200;
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 1;
      while (!done && cyc < 400) begin
         tick();
         cyc++;
      end
      check("t4_done_cycle", 32'(cyc), 129);
      tick();
      check("t4_beats_left", 32'(exp_q.size()), 0);

      // Snapshot: input change mid-frame must not reach the stream.
      set_slot(0, 10, 20);
      set_slot(1, 11, 21);
      size = 8'd2;
      push_beat(10, 20, 0, 1'b0);
      push_beat(11, 21, 1, 1'b1);
      segReady = 1'b0;
      start = 1'b1;
      tick();                       // +1
      start = 1'b0;
      set_slot(1, 99, 7);
      tick();                       // +2
      tick();                       // +3
      segReady = 1'b1;
      tick();
      tick();
      tick();
      check("t5_beats_left", 32'(exp_q.size()), 0);

      // Abort on the second handshake.
      frame3();
      push_beat(50, 60, 0, 1'b0);
      push_beat(40, 60, 1, 1'b0);
      d0 = done_cnt;
      start = 1'b1;
      tick();                       // +1
      start = 1'b0;
      tick();                       // +2
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t6_valid_after_abort", 32'(segValid), 0);
      check("t6_busy_after_abort", 32'(busy), 0);
      tick();
      tick();
      check("t6_no_done", 32'(done_cnt - d0), 0);
      check("t6_beats_left", 32'(exp_q.size()), 0);

      // start during STREAM is ignored.
      push_frame3();
      start = 1'b1;
      tick();                       // +1
      start = 1'b0;
      tick();                       // +2
      start = 1'b1;
      size = 8'd1;
      tick();                       // +3
      start = 1'b0;
      size = 8'd3;
      check("t7_idx_c3", 32'(segIndex), 2);
      check("t7_last_c3", 32'(segLast), 1);
      tick();
      check("t7_done", 32'(done), 1);
      tick();

      // abort outranks start in IDLE.
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      check("t8_busy", 32'(busy), 0);
      check("t8_valid", 32'(segValid), 0);
      tick();

      // Asynchronous reset mid-frame, then a fresh frame.
      push_frame3();
      d0 = done_cnt;
      segReady = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      #2;
      reset = 1'b0;
      #1;
      check_all_zero("t9_rst");
      exp_q.delete();
      tick();
      reset = 1'b1;
      push_frame3();
      segReady = 1'b1;
      start = 1'b1;
      tick();                       // +1
      start = 1'b0;
      check("t9_valid_c1", 32'(segValid), 1);
      check("t9_idx_c1", 32'(segIndex), 0);
      tick();
      tick();
      tick();                       // +4
      check("t9_done", 32'(done), 1);
      tick();
      check("t9_done_count", 32'(done_cnt - d0), 1);
      check("final_beats_left", 32'(exp_q.size()), 0);

      @(negedge clock);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
